video_edge_proc: RTL and testbench
==================================

VIDEO_EDGE_PROC -- requirements
Module: video_edge_proc

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel bit width.
REQ-002 SHALL have parameter IMG_HDISP, default 640: active pixels per line.
REQ-003 SHALL have parameter IMG_VDISP, default 480: active lines per frame.
REQ-004 SHALL have parameter SHARP_SHIFT, default 2: right-shift applied to gradient in sharpen mode.
REQ-005 clk  input  1  pixel clock; one clock domain; reset is synchronous and active-high.
REQ-006 rst_n  input  1  synchronous, active-high reset.
REQ-007 per_img_vsync  input  1  frame-valid, high during active frame.
REQ-008 per_img_href  input  1  line-valid.
REQ-009 per_img_clken  input  1  pixel strobe, qualified by href.
REQ-010 per_img_gray  input  DATA_W  luma pixel.
REQ-011 cfg_mode  input  2  0 magnitude, 1 binary, 2 sharpen, 3 bypass.
REQ-012 cfg_thresh  input  DATA_W  binary threshold.
REQ-013 post_img_vsync / post_img_href / post_img_clken  output  1 each  input sync signals delayed by LAT.
REQ-014 post_img_gray  output  DATA_W  processed pixel.
REQ-015 post_img_bit  output  1  edge flag (magnitude > threshold), valid in every mode.

Function
REQ-016 SHALL define LAT = 4 clk; post sync signals equal input sync signals delayed exactly LAT clk, cycle-for-cycle, independent of mode.
REQ-017 SHALL latch cfg_mode and cfg_thresh on per_img_vsync rising edge only; mid-frame changes take effect next frame.
REQ-018 SHALL keep column counter x (increments per href&clken, clears when href falls) and row counter y (increments when href falls, clears on vsync rising edge).
REQ-019 SHALL store two previous lines in two IMG_HDISP x DATA_W line buffers, written at address x on href&clken; writes with x >= IMG_HDISP SHALL be dropped, x saturates at IMG_HDISP.
REQ-020 SHALL shift a 3x3 window only on href&clken; output pixel emitted at input (x,y) is computed from window centred on (x-1,y-1).
REQ-021 SHALL compute Gx, Gy as signed DATA_W+3-bit Sobel sums; magnitude = |Gx|+|Gy| saturated to 2^DATA_W-1.
REQ-022 Mode 0: post_img_gray = magnitude. Mode 1: all-ones if magnitude > thresh else 0. Mode 2: centre + (magnitude >> SHARP_SHIFT), saturated to 2^DATA_W-1. Mode 3: centre pixel unmodified.
REQ-023 SHALL force post_img_gray and post_img_bit to 0 in modes 0-2 when input position has x<2 or y<2 (incomplete window); mode 3 passes centre.
REQ-024 SHALL drive post_img_gray and post_img_bit to 0 whenever post_img_clken is low.
REQ-025 Gaps in clken within a line SHALL not alter results; window and counters hold.
REQ-026 vsync rising mid-line SHALL clear x and y; line buffer contents need not be cleared (masked by REQ-023).

Reset
REQ-027 On rst_n high all outputs, counters, delay lines and latched cfg SHALL be 0 (mode 0, thresh 0) on next clk edge.
REQ-028 Reset asserted mid-frame SHALL abort the frame; processing resumes correctly from the next vsync rising edge.
REQ-029 Line-buffer RAM SHALL need no reset.

Structure
REQ-030 Mode encodings and LAT SHALL reside in shared package video_proc_pkg.
REQ-031 Line buffer SHALL be sub-module line_buf (single write port, single read port, one-clock read latency) instantiated twice.

Verification
REQ-032 Flat image all 100, mode 0, 8x6 frame -> post_img_gray 0 at every clken; sync outputs equal inputs delayed 4 clk.
REQ-033 Vertical step (cols 0-3 = 0, 4-7 = 200), mode 0 -> 255 (saturated) at edge columns for y>=2, 0 elsewhere.
REQ-034 Same step, mode 1, thresh 100 -> 255 and post_img_bit 1 at edge, 0 elsewhere; thresh 255 -> all 0.
REQ-035 Mode 2, SHARP_SHIFT 2, centre 250 and magnitude 40 -> 255 (saturated); centre 100, magnitude 40 -> 110.
REQ-036 Random clken gaps vs gap-free stream of same image -> identical output pixel sequence.
REQ-037 cfg_mode changed 0->3 mid-frame -> current frame stays mode 0; next frame outputs bypass; rst_n pulse mid-frame -> outputs 0 next cycle, next frame correct.

Source files
------------

// File: rtl/video_proc_pkg.sv
// Shared types and constants for the video edge processor.
package video_proc_pkg;

  // Clocks from a sampled input pixel to the matching output pixel.
  localparam int unsigned LAT = 4;

  // Width of the {vsync, href, clken} bundle carried through the delay line.
  localparam int unsigned SyncW = 3;

  typedef enum logic [1:0] {
    ModeMag    = 2'd0,
    ModeBin    = 2'd1,
    ModeSharp  = 2'd2,
    ModeBypass = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StFrame = 1'b1
  } frame_st_e;

endpackage

// File: rtl/video_edge_proc_if.sv
// Pixel stream bundle: frame/line/pixel strobes plus one luma sample.
interface video_edge_proc_if #(
  parameter int unsigned DATA_W = 8
);

  logic              vsync;
  logic              href;
  logic              clken;
  logic [DATA_W-1:0] gray;

  // Producer side of the stream.
  modport master (output vsync, href, clken, gray);

  // Consumer side of the stream.
  modport slave (input vsync, href, clken, gray);

endinterface

// File: rtl/line_buf.sv
// Single-port-write / single-port-read line store with a registered read.
// A read and write to the same address in one cycle returns the old word.
module line_buf #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 640,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rd_data_q;

  // Storage array and read register; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/video_edge_proc.sv
// 3x3 Sobel edge processor on a DVP-style luma stream. Four register stages
// (sample, window, compute, output) give a fixed latency of LAT clocks.
module video_edge_proc
  import video_proc_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IMG_HDISP   = 640,
  parameter int unsigned IMG_VDISP   = 480,
  parameter int unsigned SHARP_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,        // synchronous, active-high
  video_edge_proc_if.slave  per_img,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_thresh,
  video_edge_proc_if.master post_img,
  output logic              post_img_bit
);

  localparam int unsigned XW = $clog2(IMG_HDISP + 1);
  localparam int unsigned YW = $clog2(IMG_VDISP + 1);
  localparam int unsigned AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned GW = DATA_W + 3;
  localparam logic [XW-1:0] XMax = XW'(IMG_HDISP);
  localparam logic [YW-1:0] YMax = YW'(IMG_VDISP);

  // ---------------------------------------------------------------------------
  // Frame tracking, latched configuration and position counters
  // ---------------------------------------------------------------------------
  frame_st_e         st_q, st_d;
  logic              vsync_prev_q, href_prev_q;
  logic              vs_rise, href_fall, in_frame, pix_valid, x_in_range;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  mode_e             mode_q;
  logic [DATA_W-1:0] thresh_q;

  assign vs_rise    = per_img.vsync & ~vsync_prev_q;
  assign href_fall  = ~per_img.href & href_prev_q;
  assign in_frame   = (st_q == StFrame);
  assign pix_valid  = per_img.href & per_img.clken & in_frame;
  assign x_in_range = (x_q < XMax);

  // Frame state: a frame only opens on a genuine vsync rising edge, so a
  // reset taken mid-frame keeps everything idle until the next frame.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (vs_rise) st_d = StFrame;
      StFrame: if (!per_img.vsync) st_d = StIdle;
    endcase
  end

  // State register, edge detectors and per-frame configuration latch.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      st_q         <= StIdle;
      href_prev_q  <= 1'b0;
      // Track vsync through reset so a frame already in progress is not
      // mistaken for a new rising edge once reset drops.
      vsync_prev_q <= per_img.vsync;
      mode_q       <= ModeMag;
      thresh_q     <= '0;
    end else begin
      st_q         <= st_d;
      href_prev_q  <= per_img.href;
      vsync_prev_q <= per_img.vsync;
      if (vs_rise) begin
        mode_q   <= mode_e'(cfg_mode);
        thresh_q <= cfg_thresh;
      end
    end
  end

  // Column counter saturates at IMG_HDISP; row counter advances per line.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (vs_rise) begin
      x_q <= '0;
      y_q <= '0;
    end else if (in_frame) begin
      if (href_fall) begin
        x_q <= '0;
        if (y_q != YMax) begin
          y_q <= y_q + 1'b1;
        end
      end else if (pix_valid && x_in_range) begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: sample pixel, issue line-buffer reads
  // ---------------------------------------------------------------------------
  logic              lb_en;
  logic [AW-1:0]     lb_addr;
  logic [DATA_W-1:0] row1_rd, row2_rd;    // rows y-1 and y-2 at column x
  logic              s1_valid_q, s1_wr_q, s1_edge_q;
  logic [AW-1:0]     s1_addr_q;
  logic [DATA_W-1:0] s1_pix_q;

  assign lb_en   = pix_valid & x_in_range;
  assign lb_addr = x_q[AW-1:0];

  line_buf #(
    .DataW (DATA_W),
    .Depth (IMG_HDISP),
    .AddrW (AW)
  ) u_lb_row1 (
    .clk_i     (clk),
    .wr_en_i   (lb_en),
    .wr_addr_i (lb_addr),
    .wr_data_i (per_img.gray),
    .rd_en_i   (lb_en),
    .rd_addr_i (lb_addr),
    .rd_data_o (row1_rd)
  );

  // Row y-2 store is fed from row y-1's read data one clock later.
  line_buf #(
    .DataW (DATA_W),
    .Depth (IMG_HDISP),
    .AddrW (AW)
  ) u_lb_row2 (
    .clk_i     (clk),
    .wr_en_i   (s1_wr_q),
    .wr_addr_i (s1_addr_q),
    .wr_data_i (row1_rd),
    .rd_en_i   (lb_en),
    .rd_addr_i (lb_addr),
    .rd_data_o (row2_rd)
  );

  // Stage-1 register: the pixel and its position flags, aligned with reads.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_valid_q <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_edge_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_pix_q   <= '0;
    end else begin
      s1_valid_q <= pix_valid;
      s1_wr_q    <= lb_en;
      s1_edge_q  <= (x_q < XW'(2)) || (y_q < YW'(2));
      s1_addr_q  <= lb_addr;
      s1_pix_q   <= per_img.gray;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: 3x3 window, [row][col], row 0 = oldest line, col 2 = newest pixel
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] win_q [3][3];
  logic              s2_valid_q, s2_edge_q;

  // Window only moves on real pixels so clken gaps leave it untouched.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      s2_valid_q <= 1'b0;
      s2_edge_q  <= 1'b0;
    end else begin
      if (s1_valid_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= row2_rd;
        win_q[1][2] <= row1_rd;
        win_q[2][2] <= s1_pix_q;
      end
      s2_valid_q <= s1_valid_q;
      s2_edge_q  <= s1_edge_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: Sobel magnitude and mode selection
  // ---------------------------------------------------------------------------
  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        gx_abs, gy_abs, mag_sum;
  logic [DATA_W-1:0]    mag, centre, sharp;
  logic [DATA_W:0]      sharp_sum;
  logic                 over_thresh;
  logic [DATA_W-1:0]    res_d, res_q;
  logic                 bit_d, bit_q;

  // Gradients, |Gx|+|Gy| with saturation, and the sharpened centre.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[r][c] = $signed({3'b000, win_q[r][c]});
      end
    end
    gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    gx_abs  = gx[GW-1] ? -gx : gx;
    gy_abs  = gy[GW-1] ? -gy : gy;
    mag_sum = gx_abs + gy_abs;
    mag     = (|mag_sum[GW-1:DATA_W]) ? '1 : mag_sum[DATA_W-1:0];
    centre  = win_q[1][1];
    sharp_sum   = {1'b0, centre} + {1'b0, mag >> SHARP_SHIFT};
    sharp       = sharp_sum[DATA_W] ? '1 : sharp_sum[DATA_W-1:0];
    over_thresh = (mag > thresh_q);
  end

  // Output selection; incomplete windows yield zero except in bypass.
  always_comb begin
    res_d = '0;
    bit_d = 1'b0;
    if (s2_valid_q) begin
      bit_d = over_thresh & ~s2_edge_q;
      unique case (mode_q)
        ModeMag:    res_d = s2_edge_q ? '0 : mag;
        ModeBin:    res_d = (s2_edge_q || !over_thresh) ? '0 : '1;
        ModeSharp:  res_d = s2_edge_q ? '0 : sharp;
        ModeBypass: res_d = centre;
      endcase
    end
  end

  // Stage-3 result register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      res_q <= '0;
      bit_q <= 1'b0;
    end else begin
      res_q <= res_d;
      bit_q <= bit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: output register and matching sync delay line
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] out_gray_q;
  logic              out_bit_q;
  logic [SyncW-1:0]  sync_q [LAT];

  // Output data register and LAT-deep {vsync, href, clken} delay.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_gray_q <= '0;
      out_bit_q  <= 1'b0;
      for (int i = 0; i < int'(LAT); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      out_gray_q <= res_q;
      out_bit_q  <= bit_q;
      sync_q[0]  <= {per_img.vsync, per_img.href, per_img.clken};
      for (int i = 1; i < int'(LAT); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign post_img.vsync = sync_q[LAT-1][2];
  assign post_img.href  = sync_q[LAT-1][1];
  assign post_img.clken = sync_q[LAT-1][0];
  assign post_img.gray  = sync_q[LAT-1][0] ? out_gray_q : '0;
  assign post_img_bit   = sync_q[LAT-1][0] & out_bit_q;

endmodule

// File: tb/tb_video_edge_proc.sv
// Directed bench for video_edge_proc on an 8x6 frame. Every driven cycle
// records its expected output; the output 4 clocks later is checked.
module tb_video_edge_proc;

  localparam int unsigned DW = 8;
  localparam int HN = 4096;

  logic          clk;
  logic          rst_n;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_thresh;
  logic          post_img_bit;

  video_edge_proc_if #(.DATA_W(DW)) per_img ();
  video_edge_proc_if #(.DATA_W(DW)) post_img ();

  video_edge_proc #(
    .DATA_W      (DW),
    .IMG_HDISP   (8),
    .IMG_VDISP   (6),
    .SHARP_SHIFT (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .per_img      (per_img),
    .cfg_mode     (cfg_mode),
    .cfg_thresh   (cfg_thresh),
    .post_img     (post_img),
    .post_img_bit (post_img_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n      = 0;
  int checks = 0;
  int errors = 0;

  logic [2:0] h_sync [HN];
  logic [7:0] h_gray [HN];
  logic       h_bit  [HN];
  logic       h_chk  [HN];

  // Test images. 0 flat, 1 vertical step, 2/3 column ramps, 4 horizontal
  // step, 5 row ramp.
  function automatic logic [7:0] pix(input int kind, input int x, input int y);
    case (kind)
      0:       return 8'd100;
      1:       return (x < 4) ? 8'd0 : 8'd200;
      2:       return 8'(220 + 5 * x);
      3:       return 8'(70 + 5 * x);
      4:       return (y < 3) ? 8'd0 : 8'd200;
      default: return 8'(60 + 5 * y);
    endcase
  endfunction

  // Hand-derived saturated |Gx|+|Gy| for a full window ending at (x,y).
  function automatic int mag(input int kind, input int x, input int y);
    case (kind)
      0:       return 0;
      1:       return (x == 4 || x == 5) ? 255 : 0;
      4:       return (y == 3 || y == 4) ? 255 : 0;
      default: return 40;
    endcase
  endfunction

  task automatic expect_px(input int kind, input int mode, input int th, input int x,
                           input int y, output logic [7:0] eg, output logic eb,
                           output logic chk);
    int m;
    int c;
    int s;
    eg  = 8'd0;
    eb  = 1'b0;
    chk = 1'b1;
    if (x < 2 || y < 2) begin
      if (mode == 3) chk = 1'b0;
    end else begin
      m  = mag(kind, x, y);
      c  = int'(pix(kind, x - 1, y - 1));
      eb = (m > th);
      case (mode)
        0: eg = 8'(m);
        1: eg = eb ? 8'hFF : 8'h00;
        2: begin
          s  = c + (m >> 2);
          eg = (s > 255) ? 8'hFF : 8'(s);
        end
        default: eg = 8'(c);
      endcase
    end
  endtask

  // One clock: drive inputs, log expectation, check the output due now.
  task automatic cyc(input logic rst, input logic vs, input logic hr, input logic ce,
                     input logic [7:0] px, input logic [7:0] eg, input logic eb,
                     input logic chk);
    int j;
    rst_n         = rst;
    per_img.vsync = vs;
    per_img.href  = hr;
    per_img.clken = ce;
    per_img.gray  = px;
    j = n % HN;
    h_sync[j] = rst ? 3'b000 : {vs, hr, ce};
    h_gray[j] = rst ? 8'd0 : eg;
    h_bit[j]  = rst ? 1'b0 : eb;
    h_chk[j]  = rst ? 1'b1 : chk;
    if (rst) begin
      // Reset flushes everything still in flight.
      for (int k = 1; k <= 3; k++) begin
        if (n >= k) begin
          j = (n - k) % HN;
          h_sync[j] = 3'b000;
          h_gray[j] = 8'd0;
          h_bit[j]  = 1'b0;
          h_chk[j]  = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (n >= 3) begin
      j = (n - 3) % HN;
      checks++;
      assert ({post_img.vsync, post_img.href, post_img.clken} === h_sync[j]) else begin
        errors++;
        $error("FAIL sync cyc=%0d got=%b exp=%b", n, {post_img.vsync, post_img.href,
               post_img.clken}, h_sync[j]);
      end
      if (h_chk[j]) begin
        checks++;
        assert (post_img.gray === h_gray[j]) else begin
          errors++;
          $error("FAIL gray cyc=%0d got=%0d exp=%0d", n, post_img.gray, h_gray[j]);
        end
        checks++;
        assert (post_img_bit === h_bit[j]) else begin
          errors++;
          $error("FAIL bit cyc=%0d got=%0d exp=%0d", n, post_img_bit, h_bit[j]);
        end
      end
    end
    n++;
  endtask

  // Full 8x6 frame. mid_mode >= 0 changes cfg_mode from row 3 on; abort_y >= 0
  // pulses reset at column 3 of that row, after which outputs stay zero.
  task automatic run_frame(input int kind, input int mode, input int th, input int mid_mode,
                           input bit gaps, input int abort_y);
    logic [7:0] eg;
    logic       eb;
    logic       chk;
    bit         aborted;
    aborted    = 1'b0;
    cfg_mode   = 2'(mode);
    cfg_thresh = 8'(th);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    for (int y = 0; y < 6; y++) begin
      if (y == 3 && mid_mode >= 0) cfg_mode = 2'(mid_mode);
      for (int x = 0; x < 8; x++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 2))
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), 8'd0, 1'b0, 1'b1);
        end
        if (y == abort_y && x == 3) begin
          cyc(1'b1, 1'b1, 1'b1, 1'b1, pix(kind, x, y), 8'd0, 1'b0, 1'b1);
          aborted = 1'b1;
        end else begin
          expect_px(kind, mode, th, x, y, eg, eb, chk);
          if (aborted) begin
            eg  = 8'd0;
            eb  = 1'b0;
            chk = 1'b1;
          end
          cyc(1'b0, 1'b1, 1'b1, 1'b1, pix(kind, x, y), eg, eb, chk);
        end
      end
      // Blanking; the first cycle strobes clken with href low.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 8'd0, 1'b0, 1'b1);
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    cfg_mode      = 2'd0;
    cfg_thresh    = 8'd0;
    rst_n         = 1'b1;
    per_img.vsync = 1'b0;
    per_img.href  = 1'b0;
    per_img.clken = 1'b0;
    per_img.gray  = 8'd0;

    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);

    run_frame(0, 0, 0, -1, 1'b0, -1);     // flat image -> all zero
    run_frame(1, 0, 0, -1, 1'b0, -1);     // vertical step, magnitude
    run_frame(1, 1, 100, -1, 1'b0, -1);   // binary, low threshold
    run_frame(1, 1, 255, -1, 1'b0, -1);   // binary, threshold at max
    run_frame(2, 2, 0, -1, 1'b0, -1);     // sharpen, centre 250 saturates
    run_frame(3, 2, 0, -1, 1'b0, -1);     // sharpen, centre 100 -> 110
    run_frame(1, 0, 0, -1, 1'b1, -1);     // clken gaps, same expectations
    run_frame(4, 0, 0, -1, 1'b1, -1);     // horizontal step
    run_frame(5, 1, 39, -1, 1'b0, -1);    // magnitude 40 just above threshold
    run_frame(5, 1, 40, -1, 1'b0, -1);    // magnitude 40 equal to threshold
    run_frame(3, 0, 0, 3, 1'b0, -1);      // mode change mid-frame ignored
    run_frame(3, 3, 0, -1, 1'b0, -1);     // bypass on the following frame
    run_frame(1, 0, 0, -1, 1'b0, 3);      // reset mid-frame aborts it
    run_frame(1, 1, 100, -1, 1'b0, -1);   // next frame processed normally

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
